cla_sub_pipe: RTL and testbench
===============================

// Module: cla_sub_pipe
// PURPOSE
//   Two-stage pipelined carry-lookahead subtractor: diff = a - b - bin (mod 2^WIDTH).
//   Computed as a + ~b + ~bin on the lookahead carry tree, split at the WIDTH/2 boundary.
//   Stage 1 produces the low half and the mid borrow; stage 2 produces the high half and flags.
//   Sits next to the CLA adders as the ALU subtract/compare path; valid/ready on both sides.
// PARAMETERS
//   WIDTH  32  operand width; must be a multiple of 8 (each half is a multiple of 4-bit groups)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a/b/bin valid this cycle
//   in_ready   out  1      block accepts a/b/bin this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in (1 = subtract one more)
//   out_valid  out  1      diff/flags valid
//   out_ready  in   1      consumer takes the result this cycle
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      borrow-out: 1 iff unsigned a < b + bin
//   ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//   zero       out  1      diff == 0
// BEHAVIOUR
//   - Reset: s1_valid=0, out_valid=0; diff, bout, ovf, zero = 0. in_ready=1 from the first cycle after reset.
//   - Accept: an input transfer occurs when in_valid && in_ready. Output transfer: out_valid && out_ready.
//   - Latency: exactly 2 cycles from accept to out_valid with no stall. Throughput: 1 result per cycle.
//   - Stage 1 (on accept): register diff_lo = low half of a + ~b + ~bin.
//     Also register c_mid = carry out of the low half, plus a_hi, b_hi, and a[MSB]/b[MSB]. Set s1_valid.
//   - Stage 2: diff_hi = a_hi + ~b_hi + c_mid. Register diff = {diff_hi, diff_lo}.
//     bout = ~carry_out(high half); ovf, zero as above. Set out_valid.
//   - Flow control (no bubbles): s2_adv = s1_valid && (!out_valid || out_ready).
//     in_ready = !s1_valid || s2_adv (combinational from out_ready).
//   - Stall: while out_valid && !out_ready, diff/bout/ovf/zero are held stable.
//     s1 content is held; in_ready=0 if s1 is full.
//   - Simultaneous: output transfer and s2_adv in the same cycle -> output replaced, out_valid stays 1.
//     Accept and s2_adv in the same cycle -> s1 replaced, s1_valid stays 1.
//   - Drain: out_valid drops the cycle after the last transfer when s1 is empty. Data regs keep their last value.
//   - Wrap-around: results are modulo 2^WIDTH. E.g. 0 - 1 -> all ones, bout=1.
//   - Reset mid-operation: all in-flight results are discarded with no output transfer.
//     A transfer presented in the reset cycle is not accepted.
//   - in_valid low: s1 is not loaded; no X propagation into registered state.
// STRUCTURE
//   Shared package cla_pkg:
//     - CLA_GROUP = 4 (lookahead group width)
//     - localparam HALF = WIDTH/2
//     - function computing the group P/G -> carry equations for reuse by adder and subtractor
//   One sub-module: cla_half_add (HALF-bit lookahead adder: a, b, cin -> sum, cout).
//     Instanced twice, once per stage, with b inverted at the instance inputs.
//   The top holds stage regs, valid bits, and flag logic.
// TESTING
//   1. 32'h0000_0005 - 32'h0000_0003, bin=0 -> diff=32'h2, bout=0, ovf=0, zero=0; out_valid exactly 2 cycles after accept.
//   2. 0 - 1, bin=0 -> diff=32'hFFFF_FFFF, bout=1. Then 32'h1234_5678 - 32'h1234_5677, bin=1 -> diff=0, zero=1, bout=0.
//   3. Mid borrow across halves: 32'h0001_0000 - 32'h0000_0001 -> diff=32'h0000_FFFF, bout=0.
//      Signed overflow: 32'h8000_0000 - 1 -> diff=32'h7FFF_FFFF, ovf=1. Also 32'h7FFF_FFFF - 32'hFFFF_FFFF -> ovf=1.
//   4. Back-to-back stream of 8 ops with out_ready=1 -> 8 results on consecutive cycles, in order, in_ready never 0.
//   5. out_ready=0 for 5 cycles with 3 ops offered -> 2 accepted, in_ready=0 afterwards, diff stable.
//      Release -> remaining results in order, none lost or duplicated.
//   6. rst asserted with both stages full -> next cycle out_valid=0, diff=0, in_ready=1; no output transfer of old data.
//   Plus: scoreboard vs a - b - bin over 10k random ops with random in_valid/out_ready at WIDTH=32 and WIDTH=16.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared carry-lookahead helpers for the CLA adder family and the subtract path.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  // Group propagate/generate to carries c[0..4], c[0] being the incoming carry.
  function automatic logic [CLA_GROUP:0] cla_group_carry(
    input logic [CLA_GROUP-1:0] p,
    input logic [CLA_GROUP-1:0] g,
    input logic                 cin
  );
    logic [CLA_GROUP:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_half_add.sv
// W-bit adder built from 4-bit lookahead groups chained on the group carry.
module cla_half_add
  import cla_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / CLA_GROUP;

  logic [NG:0]          gc;
  logic [CLA_GROUP:0]   grp_c;
  logic [CLA_GROUP-1:0] grp_p;
  logic [CLA_GROUP-1:0] grp_g;

  always_comb begin
    sum   = '0;
    gc    = '0;
    grp_c = '0;
    grp_p = '0;
    grp_g = '0;
    gc[0] = cin;
    for (int i = 0; i < NG; i++) begin
      grp_p = a[i*CLA_GROUP +: CLA_GROUP] ^ b[i*CLA_GROUP +: CLA_GROUP];
      grp_g = a[i*CLA_GROUP +: CLA_GROUP] & b[i*CLA_GROUP +: CLA_GROUP];
      grp_c = cla_group_carry(grp_p, grp_g, gc[i]);
      sum[i*CLA_GROUP +: CLA_GROUP] = grp_p ^ grp_c[CLA_GROUP-1:0];
      gc[i+1] = grp_c[CLA_GROUP];
    end
    cout = gc[NG];
  end

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined subtractor diff = a - b - bin, evaluated as a + ~b + ~bin,
// low half in stage 1 and high half plus flags in stage 2, valid/ready on both sides.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int HALF = WIDTH / 2;

  logic            s1_valid;
  logic [HALF-1:0] s1_diff_lo;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;
  logic            s1_c_mid;
  logic            s1_a_msb;
  logic            s1_b_msb;

  logic [HALF-1:0] lo_sum;
  logic            lo_cout;
  logic [HALF-1:0] hi_sum;
  logic            hi_cout;
  logic            s2_adv;
  logic            accept;

  // Borrow-in becomes carry-in ~bin; the mid carry is the inverted mid borrow.
  cla_half_add #(.W(HALF)) u_lo (
    .a    (a[HALF-1:0]),
    .b    (~b[HALF-1:0]),
    .cin  (~bin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_half_add #(.W(HALF)) u_hi (
    .a    (s1_a_hi),
    .b    (~s1_b_hi),
    .cin  (s1_c_mid),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin
    s2_adv   = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_adv;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_a_hi    <= '0;
      s1_b_hi    <= '0;
      s1_c_mid   <= 1'b0;
      s1_a_msb   <= 1'b0;
      s1_b_msb   <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_diff_lo <= lo_sum;
      s1_a_hi    <= a[WIDTH-1:HALF];
      s1_b_hi    <= b[WIDTH-1:HALF];
      s1_c_mid   <= lo_cout;
      s1_a_msb   <= a[WIDTH-1];
      s1_b_msb   <= b[WIDTH-1];
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output data only moves on s2_adv, so a stalled result stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      diff      <= {hi_sum, s1_diff_lo};
      bout      <= ~hi_cout;
      ovf       <= (s1_a_msb != s1_b_msb) && (hi_sum[HALF-1] != s1_a_msb);
      zero      <= ~|{hi_sum, s1_diff_lo};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Scoreboard bench for cla_sub_pipe at WIDTH=32 and WIDTH=16: accepted inputs push
// arithmetic expectations, output monitors pop and compare on every output transfer.
module tb_cla_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int tests = 0;
  int fails = 0;

  logic        iv32, ir32, bin32, ov32, or32, bo32, of32, z32;
  logic [31:0] a32, b32, d32;
  logic        iv16, ir16, bin16, ov16, or16, bo16, of16, z16;
  logic [15:0] a16, b16, d16;

  logic [34:0] q32[$];
  logic [34:0] q16[$];

  cla_sub_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .bin(bin32),
    .out_valid(ov32), .out_ready(or32), .diff(d32), .bout(bo32), .ovf(of32), .zero(z32)
  );

  cla_sub_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16), .ovf(of16), .zero(z16)
  );

  // Expected {zero, ovf, bout, diff} from plain integer arithmetic on w-bit operands.
  function automatic logic [34:0] model(input int w, input longint a, input longint b, input logic bi);
    longint mask, r, d;
    logic bo, of, z;
    mask = (longint'(1) << w) - 1;
    r    = a - b - longint'(bi);
    d    = r & mask;
    bo   = (a < (b + longint'(bi)));
    of   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    z    = (d == 0);
    return {z, of, bo, d[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Input-side scoreboard feed
  always @(negedge clk) begin
    if (!rst && iv32 && ir32) q32.push_back(model(32, a32, b32, bin32));
    if (!rst && iv16 && ir16) q16.push_back(model(16, a16, b16, bin16));
  end

  // Output monitors
  always @(negedge clk) begin
    if (!rst && ov32 && or32) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL out32_unexpected: got %h expected no output", {z32, of32, bo32, d32});
      end else chk("out32", {z32, of32, bo32, d32}, q32.pop_front());
    end
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL out16_unexpected: got %h expected no output", {z16, of16, bo16, 16'h0, d16});
      end else chk("out16", {z16, of16, bo16, 16'h0, d16}, q16.pop_front());
    end
  end

  // A stalled output must stay valid and unchanged
  logic        hold32 = 1'b0, hold16 = 1'b0;
  logic [34:0] hold32_v, hold16_v;
  always @(negedge clk) begin
    if (hold32 && !rst) begin
      chk("stall32_valid", 35'(ov32), 35'd1);
      chk("stall32_data", {z32, of32, bo32, d32}, hold32_v);
    end
    if (hold16 && !rst) begin
      chk("stall16_valid", 35'(ov16), 35'd1);
      chk("stall16_data", {z16, of16, bo16, 16'h0, d16}, hold16_v);
    end
    hold32   <= !rst && ov32 && !or32;
    hold32_v <= {z32, of32, bo32, d32};
    hold16   <= !rst && ov16 && !or16;
    hold16_v <= {z16, of16, bo16, 16'h0, d16};
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic acc;
    int n;
    a32 = a; b32 = b; bin32 = bi; iv32 = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = ir32;
      step();
      n++;
    end
    iv32 = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send32_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain32;
    int n = 0;
    while (q32.size() != 0 && n < 500) begin step(); n++; end
    if (q32.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain32_timeout: got %0d pending expected 0", q32.size());
    end
  endtask

  task automatic drain16;
    int n = 0;
    while (q16.size() != 0 && n < 500) begin step(); n++; end
    if (q16.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain16_timeout: got %0d pending expected 0", q16.size());
    end
  endtask

  task automatic rand32;
    int acc = 0, n = 0;
    while (acc < 10000 && n < 40000) begin
      iv32  = ($urandom_range(0, 3) != 0);
      b32   = $urandom;
      a32   = ($urandom_range(0, 7) == 0) ? b32 : $urandom;
      bin32 = 1'($urandom_range(0, 1));
      or32  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (iv32 && ir32) acc++;
      step();
      n++;
    end
    iv32 = 1'b0; or32 = 1'b1;
    drain32();
  endtask

  task automatic rand16;
    int acc = 0, n = 0;
    while (acc < 10000 && n < 40000) begin
      iv16  = ($urandom_range(0, 3) != 0);
      b16   = 16'($urandom);
      a16   = ($urandom_range(0, 7) == 0) ? b16 : 16'($urandom);
      bin16 = 1'($urandom_range(0, 1));
      or16  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (iv16 && ir16) acc++;
      step();
      n++;
    end
    iv16 = 1'b0; or16 = 1'b1;
    drain16();
  endtask

  initial begin
    rst = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; bin32 = 1'b0; or32 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0; or16 = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ov32", 35'(ov32), 35'd0);
    chk("rst_ir32", 35'(ir32), 35'd1);
    chk("rst_data32", {z32, of32, bo32, d32}, 35'd0);
    chk("rst_ov16", 35'(ov16), 35'd0);
    chk("rst_data16", {z16, of16, bo16, 16'h0, d16}, 35'd0);
    step();

    // 5 - 3 with exact two-cycle latency
    or32 = 1'b1; a32 = 32'h5; b32 = 32'h3; bin32 = 1'b0; iv32 = 1'b1;
    @(negedge clk); chk("t1_accept", 35'(ir32), 35'd1);
    step(); iv32 = 1'b0;
    @(negedge clk); chk("t1_lat1", 35'(ov32), 35'd0);
    step();
    @(negedge clk); chk("t1_lat2", 35'(ov32), 35'd1);
    chk("t1_result", {z32, of32, bo32, d32}, {3'b000, 32'h0000_0002});
    step();

    // Wrap-around, zero, mid borrow, signed overflow
    send32(32'h0000_0000, 32'h0000_0001, 1'b0);
    send32(32'h1234_5678, 32'h1234_5677, 1'b1);
    send32(32'h0001_0000, 32'h0000_0001, 1'b0);
    send32(32'h8000_0000, 32'h0000_0001, 1'b0);
    send32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain32();

    // Back-to-back stream of 8
    or32 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a32 = $urandom; b32 = $urandom; bin32 = 1'($urandom_range(0, 1)); iv32 = 1'b1;
      @(negedge clk);
      chk("t4_ready", 35'(ir32), 35'd1);
      if (i >= 2) chk("t4_stream", 35'(ov32), 35'd1);
      step();
    end
    iv32 = 1'b0;
    repeat (2) begin @(negedge clk); chk("t4_tail", 35'(ov32), 35'd1); step(); end
    @(negedge clk); chk("t4_drain", 35'(ov32), 35'd0);
    step();

    // Backpressure: 3 ops offered with out_ready low for 5 cycles
    or32 = 1'b0;
    a32 = 32'h0000_0010; b32 = 32'h0000_0001; bin32 = 1'b0; iv32 = 1'b1;
    @(negedge clk); chk("t5_acc0", 35'(ir32), 35'd1); step();
    a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D; bin32 = 1'b1;
    @(negedge clk); chk("t5_acc1", 35'(ir32), 35'd1); step();
    a32 = 32'h0000_0000; b32 = 32'h8000_0000; bin32 = 1'b0;
    repeat (3) begin @(negedge clk); chk("t5_full", 35'(ir32), 35'd0); step(); end
    or32 = 1'b1;
    @(negedge clk); chk("t5_release", 35'(ir32), 35'd1); step();
    iv32 = 1'b0;
    drain32();
    @(negedge clk); chk("t5_empty", 35'(ov32), 35'd0); step();

    // Reset with both stages full; the op offered during reset is dropped
    or32 = 1'b0;
    a32 = 32'h1111_1111; b32 = 32'h0000_0001; bin32 = 1'b0; iv32 = 1'b1;
    @(negedge clk); step();
    a32 = 32'h2222_2222;
    @(negedge clk); step();
    rst = 1'b1; a32 = 32'h3333_3333;
    @(negedge clk); step();
    rst = 1'b0; iv32 = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("t6_ov", 35'(ov32), 35'd0);
    chk("t6_data", {z32, of32, bo32, d32}, 35'd0);
    chk("t6_ir", 35'(ir32), 35'd1);
    step();
    or32 = 1'b1;
    repeat (3) begin @(negedge clk); chk("t6_quiet", 35'(ov32), 35'd0); step(); end

    // Random traffic on both widths
    fork
      rand32();
      rand16();
    join
    chk("end_q32", 35'(q32.size()), 35'd0);
    chk("end_q16", 35'(q16.size()), 35'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
